// File: rtl/ram_scan_pkg.sv
// Shared types for the RAM scan sequencer feeding the 7-seg decoders.
// Optional reverse scan is enabled with RAM_SCAN_REVERSE_EN.
package ram_scan_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 4;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/ram_scan_sequencer_tick_gen.sv
// Free-running scan period counter with hold and clear.
// One-cycle tick on the last count of each period.
module tick_gen #(
  parameter int TICK_COUNT = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_COUNT);
  localparam logic [CW-1:0] LAST = CW'(TICK_COUNT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_scan_sequencer.sv
// Scanning RAM reader presenting aligned (rd_addr, rd_data) to the display.
// Define RAM_SCAN_REVERSE_EN to add the scan_down input.
module ram_scan_sequencer #(
  parameter int ADDR_WIDTH = ram_scan_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_scan_pkg::DATA_WIDTH,
  parameter int TICK_COUNT = 50000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pause,
  input  logic                  step,
`ifdef RAM_SCAN_REVERSE_EN
  input  logic                  scan_down,
`endif
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  import ram_scan_pkg::*;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  scan_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] scan_q, scan_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q;
  logic                  step_q;
  logic                  tick;
  logic                  step_edge;
  logic                  adv;
  logic                  down;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  tick_gen #(
    .TICK_COUNT(TICK_COUNT)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (state_q == RUN),
    .clear  (state_q == PAUSE && !pause),
    .tick   (tick)
  );

`ifdef RAM_SCAN_REVERSE_EN
  assign down = scan_down;
`else
  assign down = 1'b0;
`endif

  // Step edges only count once the FSM has settled in PAUSE.
  assign step_edge = (state_q == PAUSE) && step && !step_q;
  assign adv       = tick || step_edge;

  always_comb begin
    scan_d = scan_q;
    if (adv) begin
      scan_d = down ? scan_q - 1'b1 : scan_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     state_d = pause ? PAUSE : RUN;
      PAUSE:   state_d = pause ? PAUSE : RUN;
      default: state_d = RUN;
    endcase
  end

  // Write-first bypass keeps rd_data coherent with a same-address write.
  always_comb begin
    rd_data_d = mem[scan_q];
    if (wr_en && (wr_addr == scan_q)) begin
      rd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      scan_q     <= '0;
      step_q     <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_q     <= scan_d;
      step_q     <= step;
      rd_addr_q  <= scan_q;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= 1'b1;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
